// File: rtl/lsu_initiator.sv
// Load/store initiator: one request at a time, one memory access cycle, registered response.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses instead of issuing them.
module lsu_initiator #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [1:0]      Mren,
  output logic [1:0]      Mwen,
  output logic [XLEN-1:0] raddr,
  output logic [XLEN-1:0] waddr,
  output logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              reject_new;
  logic [XLEN-1:0]   load_ext;
  logic [XLEN-1:0]   store_masked;
  logic              in_access;

  // Rejection is decided on the incoming request so a rejected request never reaches ACCESS.
  always_comb begin
    reject_new = (req_size == 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_size == 2'b10 && req_addr[0])
      reject_new = 1'b1;
    if (req_size == 2'b11 && req_addr[1:0] != 2'b00)
      reject_new = 1'b1;
`endif
  end

  always_comb begin
    load_ext = rdata;
    case (size_q)
      2'b01:   load_ext = {{(XLEN-8){signed_q & rdata[7]}}, rdata[7:0]};
      2'b10:   load_ext = {{(XLEN-16){signed_q & rdata[15]}}, rdata[15:0]};
      default: load_ext = rdata;
    endcase
  end

  always_comb begin
    store_masked = wdata_q;
    case (size_q)
      2'b01:   store_masked = {{(XLEN-8){1'b0}}, wdata_q[7:0]};
      2'b10:   store_masked = {{(XLEN-16){1'b0}}, wdata_q[15:0]};
      default: store_masked = wdata_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    signed_d   = signed_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
      end
      S_ACCESS: begin
        rdata_d = we_q ? '0 : load_ext;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        req_ready  = resp_ready;
        if (resp_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Accepting in RESP overrides the IDLE return, giving back-to-back operation.
    if (req_valid && req_ready) begin
      we_d     = req_we;
      size_d   = req_size;
      signed_d = req_signed;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
      if (reject_new) begin
        err_d   = 1'b1;
        rdata_d = '0;
        state_d = S_RESP;
      end else begin
        state_d = S_ACCESS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign in_access  = (state_q == S_ACCESS);
  assign Mren       = (in_access && !we_q && !rst) ? size_q : 2'b00;
  assign Mwen       = (in_access &&  we_q && !rst) ? size_q : 2'b00;
  assign raddr      = (in_access && !we_q) ? addr_q : '0;
  assign waddr      = (in_access &&  we_q) ? addr_q : '0;
  assign wdata      = (in_access &&  we_q) ? store_masked : '0;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_initiator.sv
// Self-checking bench for lsu_initiator: directed table, corner sequences, randomized vs. model.
module tb_lsu_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  Mren, Mwen;
  logic [31:0] raddr, waddr, wdata, rdata;
  logic [31:0] mem_val;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Memory returns its word only while a read is being issued.
  assign rdata = (Mren != 2'b00) ? mem_val : 32'h0;

  lsu_initiator #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .Mren(Mren), .Mwen(Mwen),
    .raddr(raddr), .waddr(waddr), .wdata(wdata), .rdata(rdata)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mem;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour written from the access rules with plain arithmetic.
  function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wd_in,
                                input logic [31:0] mem, output logic err,
                                output logic [31:0] rd, output logic [31:0] wd);
    longint bits, v;
    err = (size == 0);
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == 2 && (addr % 2) != 0) err = 1'b1;
    if (size == 3 && (addr % 4) != 0) err = 1'b1;
`endif
    bits = (size == 1) ? 8 : (size == 2) ? 16 : 32;
    wd = 32'(longint'(wd_in) % (64'd1 << bits));
    rd = 32'h0;
    if (!err && !we) begin
      v = longint'(mem) % (64'd1 << bits);
      if (sgn && bits < 32 && v >= (64'd1 << (bits - 1)))
        v = v - (64'd1 << bits);
      rd = v[31:0];
    end
  endfunction

  // Runs one transaction starting from IDLE, #1 after a rising edge.
  task automatic run_txn(input int id, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mem,
                         input int hold, input logic [31:0] exp_rd, input logic exp_err,
                         input logic [31:0] exp_wd);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    mem_val = mem; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!exp_err) begin
      check("acc_Mren",  32'(Mren),  we ? 32'd0 : 32'(size));
      check("acc_Mwen",  32'(Mwen),  we ? 32'(size) : 32'd0);
      check("acc_raddr", raddr, we ? 32'h0 : addr);
      check("acc_waddr", waddr, we ? addr : 32'h0);
      check("acc_wdata", wdata, we ? exp_wd : 32'h0);
      check("acc_resp_valid", 32'(resp_valid), 32'd0);
      check("acc_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end else begin
      check("rej_no_access", 32'({Mren, Mwen}), 32'd0);
    end
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_err",   32'(resp_err),   32'(exp_err));
    check("resp_rdata", resp_rdata, exp_rd);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      check("hold_resp_rdata", resp_rdata, exp_rd);
      check("hold_no_access", 32'({Mren, Mwen}), 32'd0);
    end
    resp_ready = 1'b1;
    #1;
    check("resp_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("after_resp_valid", 32'(resp_valid), 32'd0);
    $display("txn %0d we=%0d size=%0d sgn=%0d addr=%h wd=%h mem=%h -> rdata=%h err=%0d",
             id, we, size, sgn, addr, wd, mem, resp_rdata, resp_err);
  endtask

  initial begin
    logic        e_err;
    logic [31:0] e_rd, e_wd;
    logic        misal_err;

`ifdef LSU_MISALIGN_TRAP_EN
    misal_err = 1'b1;
`else
    misal_err = 1'b0;
`endif
    vecs[0] = '{1'b1, 2'b11, 1'b0, 32'h80000000, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 2'b01, 1'b1, 32'h80000000, 32'h0, 32'h000000EF, 32'hFFFFFFEF, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 2'b01, 1'b0, 32'h80000000, 32'h0, 32'h000000EF, 32'h000000EF, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 2'b10, 1'b0, 32'h80000004, 32'h12345678, 32'h0, 32'h0, 1'b0, 32'h00005678};
    vecs[4] = '{1'b0, 2'b00, 1'b1, 32'h80000008, 32'h0, 32'h55555555, 32'h0, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 2'b10, 1'b1, 32'h8000000C, 32'h0, 32'h00008001, 32'hFFFF8001, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 2'b11, 1'b1, 32'h80000002, 32'h0, 32'hCAFEF00D,
                misal_err ? 32'h0 : 32'hCAFEF00D, misal_err, 32'h0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0; mem_val = 32'h0;

    // Reset for two cycles, then idle.
    @(posedge clk); @(posedge clk); #1;
    check("rst_Mren", 32'(Mren), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_resp_valid", 32'(resp_valid), 32'd0);
    check("idle_resp_err", 32'(resp_err), 32'd0);
    check("idle_resp_rdata", resp_rdata, 32'h0);
    check("idle_MrenMwen", 32'({Mren, Mwen}), 32'd0);
    check("idle_addrs", raddr | waddr | wdata, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_txn(i, vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wd,
              vecs[i].mem, (i == 1) ? 2 : 0, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_wd);

    // Backpressure for 3 cycles, then a back-to-back request with no IDLE gap.
    req_we = 1'b0; req_size = 2'b11; req_signed = 1'b0; req_addr = 32'h80000010;
    mem_val = 32'h11223344; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_acc_Mren", 32'(Mren), 32'd3);
    @(posedge clk); #1;
    for (int h = 0; h < 3; h++) begin
      check("b2b_hold_valid", 32'(resp_valid), 32'd1);
      check("b2b_hold_rdata", resp_rdata, 32'h11223344);
      check("b2b_hold_Mren", 32'(Mren), 32'd0);
      check("b2b_hold_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01;
    req_addr = 32'h80000020; req_wdata = 32'hFFFFFFAB;
    #1;
    check("b2b_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    check("b2b_Mwen", 32'(Mwen), 32'd1);
    check("b2b_waddr", waddr, 32'h80000020);
    check("b2b_wdata", wdata, 32'h000000AB);
    check("b2b_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    check("b2b_resp_valid2", 32'(resp_valid), 32'd1);
    check("b2b_resp_rdata", resp_rdata, 32'h0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    $display("txn b2b: load word then store byte complete");

    // Reset asserted during a store's access cycle.
    req_we = 1'b1; req_size = 2'b11; req_addr = 32'h80000040; req_wdata = 32'h0BADF00D;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstacc_Mwen_pre", 32'(Mwen), 32'd3);
    rst = 1'b1;
    #1;
    check("rstacc_Mwen_gated", 32'(Mwen), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstacc_resp_valid", 32'(resp_valid), 32'd0);
    check("rstacc_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("rstacc_no_resp", 32'(resp_valid), 32'd0);
    check("rstacc_no_access", 32'({Mren, Mwen}), 32'd0);
    $display("txn rst-mid-access: store dropped");

    // Randomized transactions against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic        r_we, r_sgn;
      logic [1:0]  r_size;
      logic [31:0] r_addr, r_wd, r_mem;
      r_we   = 1'($urandom_range(0, 1));
      r_sgn  = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_addr = $urandom;
      r_wd   = $urandom;
      r_mem  = $urandom;
      model(r_we, r_size, r_sgn, r_addr, r_wd, r_mem, e_err, e_rd, e_wd);
      run_txn(100 + i, r_we, r_size, r_sgn, r_addr, r_wd, r_mem,
              int'($urandom_range(0, 2)), e_rd, e_err, e_wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_initiator.md
Name: lsu_initiator

Overview:
- Load/store initiator that drives the DPI-backed data-memory port (Mren/Mwen/raddr/waddr/wdata/rdata).
- Sits between the execute stage and data memory.
- Accepts one load/store request at a time over a valid/ready handshake and issues exactly one memory access cycle.
- Registers the read data and returns it, size- and sign-adjusted, over a valid/ready response channel.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  initiator can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 = illegal, 01 = byte, 10 = half, 11 = word
- req_signed  input  1  sign-extend load result (byte/half only)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  response present
- resp_ready  input  1  consumer takes response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  request rejected, no memory access made
- Mren  output  2  memory read length, same encoding as req_size; 00 = no read
- Mwen  output  2  memory write length, same encoding; 00 = no write
- raddr  output  32  read address
- waddr  output  32  write address
- wdata  output  32  write data, masked to size
- rdata  input  32  right-aligned read data from memory, valid combinationally during the access cycle

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- State machine: IDLE, ACCESS, RESP.
- Reset: state = IDLE. All held registers cleared, so resp_valid, resp_err, resp_rdata = 0 and Mren, Mwen, raddr, waddr, wdata = 0.
- Reset gating: Mren and Mwen are additionally gated combinationally with !rst, so no access is ever issued in a reset cycle, including reset asserted mid-ACCESS. A response pending when reset arrives is dropped.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch we, size, signed, addr, wdata.
  - Next state is ACCESS, or RESP with err when the request is rejected (see Rejection).
- ACCESS (exactly one cycle):
  - req_ready = 0.
  - Load: Mren = size, raddr = addr, Mwen = 0.
  - Store: Mwen = size, waddr = addr, wdata = wdata masked to size (byte: bits 31:8 = 0; half: bits 31:16 = 0), Mren = 0.
  - On the clock edge, rdata is captured and extended:
    - byte: sign- or zero-extend bit 7;
    - half: sign- or zero-extend bit 15;
    - word: passthrough, req_signed ignored.
  - Next state is RESP.
- In every cycle other than ACCESS: Mren = Mwen = 0 and addresses/wdata = 0.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable until the handshake.
  - req_ready = resp_ready, which enables back-to-back operation.
  - On resp_ready without a new request: go to IDLE.
  - On resp_ready & req_valid: latch the new request and go to ACCESS (or RESP with err if it is rejected).
  - Without resp_ready: stay in RESP.
- Throughput: 2 cycles per request sustained; latency from request accept to resp_valid = 2 edges.
- Rejection: req_size = 00 is rejected. The block skips ACCESS, goes straight to RESP with resp_err = 1 and resp_rdata = 0, and issues no memory access.
- Store responses: resp_rdata = 0, resp_err = 0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0] = 1 or a word access with addr[1:0] != 00 is rejected exactly like size 00: no memory access, RESP with resp_err = 1 and resp_rdata = 0.
- Undefined: misaligned accesses are issued unmodified to memory and complete normally; resp_err is raised only for size 00.

Test Plan:
- Reset then idle: rst = 1 for 2 cycles, then released -> req_ready = 1, resp_valid = 0, Mren = Mwen = 00, all addresses = 0.
- Store word, then load signed byte:
  - Store word 0xDEADBEEF to 0x80000000 -> one cycle with Mwen = 11, waddr = 0x80000000, wdata = 0xDEADBEEF; resp_err = 0.
  - Load byte at 0x80000000, signed, memory returns 0x000000EF -> resp_rdata = 0xFFFFFFEF.
  - Same load unsigned -> resp_rdata = 0x000000EF.
- Store half masking: store half with req_wdata = 0x12345678 -> wdata = 0x00005678, Mwen = 10 for exactly one cycle.
- Backpressure then back-to-back:
  - Hold resp_ready = 0 for 3 cycles during RESP -> resp_valid and resp_rdata stable, Mren = 00 throughout.
  - Then assert resp_ready with req_valid = 1 -> next cycle is ACCESS with no IDLE gap.
- Illegal size and reset mid-access:
  - Request with req_size = 00 -> no Mren/Mwen activity, resp_valid next cycle, resp_err = 1.
  - Assert rst during ACCESS of a store -> Mwen = 00 in that cycle, state IDLE afterwards, no response.
- Misaligned word load at 0x80000002:
  - With LSU_MISALIGN_TRAP_EN -> resp_err = 1, no read issued.
  - Without it -> Mren = 11, raddr = 0x80000002, resp_err = 0.
